bus_arbiter: RTL and testbench

Shares the CPU-owned system bus between the CPU and up to NUM_REQ auxiliary bus masters (DMA, debug port, video fetch). It uses the CPU's busrq_n/busack_n handoff. The arbiter drives busrq_n toward the CPU, waits for busack_n, and grants the bus to one requester at a time in round-robin order. It enforces a maximum hold time per grant and a minimum CPU window between grants. It sits beside the cpu instance in the top level; masters' bus drivers are enabled by grant.

---
 rtl/bus_arb_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_pick.sv | 36 +++
 rtl/bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and defaults for the system-bus arbiter and for
// other blocks that reuse its round-robin picker.
package bus_arb_pkg;

    // Arbiter FSM states, in handshake order.
    typedef enum logic [2:0] {
        CPU_OWN    = 3'd0,
        REQ_CPU    = 3'd1,
        GRANT      = 3'd2,
        TURNAROUND = 3'd3,
        RELEASE    = 3'd4
    } arb_state_t;

    // Default parameter values.
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_HOLD   = 32;
    localparam int DEF_CPU_WINDOW = 4;

    // Next round-robin start position after index idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans req starting at ptr and
// wrapping around; the first set bit wins. Winner is returned both as a
// one-hot vector and as an index. With no request set both outputs are zero.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         winner,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] cand;

    // Walk the request vector from ptr, take the first active requester.
    always_comb begin
        found  = 1'b0;
        cand   = '0;
        idx    = '0;
        winner = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        for (int j = 0; j < N; j++) begin
            winner[j] = found && (idx == IW'(j));
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the CPU-owned system bus with up to NUM_REQ auxiliary
// masters. The bus is borrowed from the CPU through busrq_n/busack_n, given to
// one master at a time in round-robin order, taken back after at most MAX_HOLD
// cycles, and returned to the CPU for at least CPU_WINDOW cycles between grants.
// All outputs are decoded from the registered state, so they follow the state
// register by one edge and have no combinational path from any input.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_HOLD   = DEF_MAX_HOLD,
    parameter int CPU_WINDOW = DEF_CPU_WINDOW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       busack_n,
    output logic                       busrq_n,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic [NUM_REQ-1:0]         revoked,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int WW = $clog2(CPU_WINDOW + 1);

    typedef logic [NUM_REQ-1:0] grant_vec_t;

    // FSM and bookkeeping
    arb_state_t    state_q,   state_d;
    grant_vec_t    win_vec_q, win_vec_d;
    logic [IW-1:0] win_idx_q, win_idx_d;
    logic [IW-1:0] ptr_q,     ptr_d;
    grant_vec_t    mask_q,    mask_d;
    logic [HW-1:0] hold_q,    hold_d;
    logic [WW-1:0] wcnt_q,    wcnt_d;
    logic          tmo_q,     tmo_d;

    // Registered outputs
    logic          busrq_n_q, busrq_n_d;
    grant_vec_t    grant_q,   grant_d;
    logic [IW-1:0] owner_q,   owner_d;
    grant_vec_t    revoked_q, revoked_d;
    logic          busy_q,    busy_d;

    // Arbitration helpers
    grant_vec_t    eligible;
    grant_vec_t    pick_vec;
    logic [IW-1:0] pick_idx;
    logic          any_elig;
    logic          win_sat;
    logic          hold_last;
    logic          win_req;

    assign eligible  = req & ~mask_q;
    assign any_elig  = |eligible;
    assign win_sat   = (wcnt_q == WW'(CPU_WINDOW));
    assign hold_last = (hold_q == HW'(MAX_HOLD - 1));
    assign win_req   = |(req & win_vec_q);

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .req    (eligible),
        .ptr    (ptr_q),
        .winner (pick_vec),
        .idx    (pick_idx)
    );

    // Next-state, counter, mask and output decode.
    always_comb begin
        state_d   = state_q;
        win_vec_d = win_vec_q;
        win_idx_d = win_idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        wcnt_d    = wcnt_q;
        tmo_d     = tmo_q;
        // A master that lets go of req is forgiven for an earlier timeout.
        mask_d    = mask_q & req;

        case (state_q)
            CPU_OWN: begin
                if (!win_sat) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (win_sat && any_elig) begin
                    state_d = REQ_CPU;
                end
            end
            REQ_CPU: begin
                if (!busack_n && any_elig) begin
                    state_d   = GRANT;
                    win_vec_d = pick_vec;
                    win_idx_d = pick_idx;
                    ptr_d     = IW'(rr_next(int'(pick_idx), NUM_REQ));
                    hold_d    = '0;
                    tmo_d     = 1'b0;
                end else if (!any_elig) begin
                    // Everyone gave up before the CPU answered; hand back.
                    state_d = RELEASE;
                end
            end
            GRANT: begin
                if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
                if (!win_req) begin
                    state_d = TURNAROUND;
                end else if (hold_last) begin
                    state_d = TURNAROUND;
                    tmo_d   = 1'b1;
                    mask_d  = (mask_q & req) | win_vec_q;
                end
            end
            TURNAROUND: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (busack_n) begin
                    state_d = CPU_OWN;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase

        busrq_n_d = !(state_q inside {REQ_CPU, GRANT, TURNAROUND});
        grant_d   = (state_q == GRANT) ? win_vec_q : '0;
        owner_d   = (state_q == GRANT) ? win_idx_q : owner_q;
        revoked_d = (state_q == TURNAROUND && tmo_q) ? win_vec_q : '0;
        busy_d    = (state_q != CPU_OWN);
    end

    // Single state/output register; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CPU_OWN;
            win_vec_q <= '0;
            win_idx_q <= '0;
            ptr_q     <= '0;
            mask_q    <= '0;
            hold_q    <= '0;
            wcnt_q    <= WW'(CPU_WINDOW);
            tmo_q     <= 1'b0;
            busrq_n_q <= 1'b1;
            grant_q   <= '0;
            owner_q   <= '0;
            revoked_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_vec_q <= win_vec_d;
            win_idx_q <= win_idx_d;
            ptr_q     <= ptr_d;
            mask_q    <= mask_d;
            hold_q    <= hold_d;
            wcnt_q    <= wcnt_d;
            tmo_q     <= tmo_d;
            busrq_n_q <= busrq_n_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            revoked_q <= revoked_d;
            busy_q    <= busy_d;
        end
    end

    assign busrq_n = busrq_n_q;
    assign grant   = grant_q;
    assign owner   = owner_q;
    assign revoked = revoked_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter with a delay-line CPU model.
module tb_bus_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int MAX_HOLD   = 8;
    localparam int CPU_WINDOW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       busack_n;
    logic       busrq_n;
    logic [3:0] grant;
    logic [1:0] owner;
    logic [3:0] revoked;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cpu_dly  = 1;
    bit cpu_stall = 1'b0;
    int rev_cnt  = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] own;
    } exp_t;
    exp_t exp_q[$];

    bus_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MAX_HOLD   (MAX_HOLD),
        .CPU_WINDOW (CPU_WINDOW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .busack_n (busack_n),
        .busrq_n  (busrq_n),
        .grant    (grant),
        .owner    (owner),
        .revoked  (revoked),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [1:0] o);
        exp_t e;
        e.gnt = g;
        e.own = o;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input int lim);
        int n = 0;
        while (grant == 4'b0000 && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_release(input int lim);
        int n = 0;
        while (grant != 4'b0000 && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_busrq_n", 32'(busrq_n), 1);
        check_val("rst_grant",   32'(grant),   0);
        check_val("rst_owner",   32'(owner),   0);
        check_val("rst_revoked", 32'(revoked), 0);
        check_val("rst_busy",    32'(busy),    0);
        reset = 1'b0;
    endtask

    // CPU: busack_n follows busrq_n through a cpu_dly-deep delay line.
    initial begin
        logic hist [8];
        for (int i = 0; i < 8; i++) hist[i] = 1'b1;
        busack_n = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = busrq_n;
            busack_n = cpu_stall ? 1'b1 : hist[cpu_dly-1];
        end
    end

    // Output monitor: scoreboard pop on each new grant, CPU-window gap check.
    initial begin
        logic [3:0] prev_g = 4'b0000;
        logic       prev_rq = 1'b1;
        int         hi_run = 0;
        bit         had_grant = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                had_grant = 1'b0;
                hi_run = 0;
            end else begin
                if (grant != 4'b0000 && prev_g == 4'b0000) begin
                    had_grant = 1'b1;
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_grant", 32'(grant), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("sb_grant", 32'(grant), 32'(e.gnt));
                        check_val("sb_owner", 32'(owner), 32'(e.own));
                    end
                end
                if (revoked != 4'b0000) rev_cnt++;
                if (busrq_n) begin
                    hi_run++;
                end else begin
                    if (prev_rq && had_grant)
                        check_val("cpu_window_gap", 32'(hi_run >= CPU_WINDOW), 1);
                    hi_run = 0;
                end
            end
            prev_g = grant;
            prev_rq = busrq_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_exp [6];
        logic [3:0] g;
        int len, g_cnt, lo_cnt, rv_cnt;

        reset = 1'b1;
        req   = 4'b0000;
        do_reset();

        // Single request with a two-cycle CPU answer
        cpu_dly = 3;
        push_exp(4'b0010, 2'd1);
        req = 4'b0010;
        @(negedge clk);
        check_val("t1_busrq_lat_n", 32'(busrq_n), 1);
        @(negedge clk);
        check_val("t1_busrq_lat_n1", 32'(busrq_n), 0);
        wait_grant(40);
        check_val("t1_grant", 32'(grant), 32'h2);
        check_val("t1_owner", 32'(owner), 1);
        repeat (3) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check_val("t1_grant_k", 32'(grant), 32'h2);
        @(negedge clk);
        check_val("t1_grant_k1", 32'(grant), 0);
        check_val("t1_busrq_k1", 32'(busrq_n), 0);
        @(negedge clk);
        check_val("t1_busrq_k2", 32'(busrq_n), 1);
        wait_idle(40);
        check_val("t1_idle", 32'(busy), 0);
        check_val("t1_owner_kept", 32'(owner), 1);

        // Round robin over 4'b1011 from a fresh pointer
        do_reset();
        cpu_dly = 1;
        rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        for (int k = 0; k < 6; k++) push_exp(rr_exp[k], (k % 3 == 2) ? 2'd3 : 2'(k % 3));
        req = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_grant(60);
            check_val("rr_order", 32'(grant), 32'(rr_exp[k]));
            g = grant;
            repeat (2) @(negedge clk);
            req = req & ~g;
            wait_release(20);
            check_val("rr_release", 32'(grant), 0);
            req = req | g;
        end
        req = 4'b0000;
        wait_idle(40);
        check_val("rr_idle", 32'(busy), 0);

        // Timeout: req[2] held until revoked, then masked until it drops
        push_exp(4'b0100, 2'd2);
        req = 4'b0100;
        wait_grant(40);
        check_val("to_grant", 32'(grant), 32'h4);
        len = 0;
        while (grant == 4'b0100 && len < 40) begin
            len++;
            @(negedge clk);
        end
        check_val("to_hold_len", 32'(len), MAX_HOLD);
        check_val("to_revoked", 32'(revoked), 32'h4);
        @(negedge clk);
        check_val("to_revoked_pulse", 32'(revoked), 0);
        g_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (grant != 4'b0000) g_cnt++;
        end
        check_val("to_masked_no_grant", 32'(g_cnt), 0);
        check_val("to_masked_idle", 32'(busy), 0);
        req = 4'b0000;
        @(negedge clk);
        push_exp(4'b0100, 2'd2);
        req = 4'b0100;
        wait_grant(40);
        check_val("to_regrant", 32'(grant), 32'h4);
        repeat (2) @(negedge clk);
        req = 4'b0000;
        wait_release(20);
        wait_idle(40);
        check_val("to_idle", 32'(busy), 0);

        // Abort: one-cycle request, CPU answers late
        repeat (8) @(negedge clk);
        cpu_dly = 4;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        g_cnt = 0;
        lo_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (grant != 4'b0000) g_cnt++;
            if (!busrq_n) lo_cnt++;
        end
        check_val("ab_no_grant", 32'(g_cnt), 0);
        check_val("ab_busrq_low_cycles", 32'(lo_cnt), 1);
        check_val("ab_busrq_back", 32'(busrq_n), 1);
        check_val("ab_idle", 32'(busy), 0);

        // Reset in the middle of a grant
        cpu_dly = 1;
        repeat (6) @(negedge clk);
        push_exp(4'b0010, 2'd1);
        req = 4'b0010;
        wait_grant(40);
        check_val("mr_grant", 32'(grant), 32'h2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("mr_grant_dropped", 32'(grant), 0);
        check_val("mr_busrq_n", 32'(busrq_n), 1);
        check_val("mr_busy", 32'(busy), 0);
        check_val("mr_revoked", 32'(revoked), 0);
        check_val("mr_owner", 32'(owner), 0);
        reset = 1'b0;
        push_exp(4'b0001, 2'd0);
        req = 4'b1111;
        wait_grant(40);
        check_val("mr_ptr_zero", 32'(grant), 32'h1);
        repeat (2) @(negedge clk);
        req = 4'b0000;
        wait_release(20);
        wait_idle(40);
        check_val("mr_idle", 32'(busy), 0);

        // Slow CPU: busack_n withheld for a long time
        repeat (6) @(negedge clk);
        cpu_stall = 1'b1;
        req = 4'b0001;
        g_cnt = 0;
        rv_cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (grant != 4'b0000) g_cnt++;
            if (revoked != 4'b0000) rv_cnt++;
        end
        check_val("sc_no_grant", 32'(g_cnt), 0);
        check_val("sc_no_revoke", 32'(rv_cnt), 0);
        check_val("sc_busrq_held", 32'(busrq_n), 0);
        check_val("sc_busy", 32'(busy), 1);
        push_exp(4'b0001, 2'd0);
        cpu_stall = 1'b0;
        wait_grant(40);
        check_val("sc_grant", 32'(grant), 32'h1);
        repeat (2) @(negedge clk);
        req = 4'b0000;
        wait_release(20);
        wait_idle(40);
        check_val("sc_idle", 32'(busy), 0);

        repeat (4) @(negedge clk);
        check_val("sb_all_seen", 32'(exp_q.size()), 0);
        check_val("revoke_count", 32'(rev_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
